// File: rtl/fetch_seq_if.sv
// fetch_seq_if: counter control, byte memory, instruction hand-off and branch signals
// of the fetch sequencer. master = sequencer side, slave = environment side.
interface fetch_seq_if;
    logic [15:0] pc_ao;
    logic [15:0] pc_ai;
    logic        pc_lrc;
    logic        pc_ini;
    logic        pc_oe;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [7:0]  ir_op;
    logic [23:0] ir_arg;
    logic [1:0]  ir_len;
    logic        br_take;
    logic [15:0] br_addr;
    logic        flt;

    modport master (
        input  pc_ao, mem_ack, mem_rdata, ir_ready, br_take, br_addr,
        output pc_ai, pc_lrc, pc_ini, pc_oe, mem_req, ir_valid, ir_op, ir_arg, ir_len, flt
    );

    modport slave (
        output pc_ao, mem_ack, mem_rdata, ir_ready, br_take, br_addr,
        input  pc_ai, pc_lrc, pc_ini, pc_oe, mem_req, ir_valid, ir_op, ir_arg, ir_len, flt
    );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: fetches 1-4 byte instructions through the program counter and a byte memory.
// Define FETCH_FAULT_EN to trap opcode fetches outside [RESET_VEC, ADDR_LIMIT].
module fetch_seq #(
    parameter logic [15:0] RESET_VEC  = 16'h8000,
    parameter logic [15:0] ADDR_LIMIT = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    fetch_seq_if.master bus
);
`ifdef FETCH_FAULT_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        REQ    = 3'd1,
        INC    = 3'd2,
        SETTLE = 3'd3,
        ISSUE  = 3'd4,
        REDIR  = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic        need_op;
    logic [1:0]  idx;
    logic        br_pend;
    logic [15:0] br_tgt;
    logic [7:0]  op_q;
    logic [23:0] arg_q;
    logic [1:0]  len_q;
    logic        pend_any;
    logic        addr_bad;
    logic        lat_byte;
    logic        op_done;
    logic        clr_pend;

    function automatic logic out_of_range(input logic [15:0] a);
        return (a > ADDR_LIMIT) || (a < RESET_VEC);
    endfunction

    // A same-cycle br_take counts as pending so it beats a completing handshake.
    assign pend_any = (state != FAULT) && (br_pend || bus.br_take);
    assign addr_bad = CHK_EN && need_op && out_of_range(bus.pc_ao);

    assign bus.pc_ai  = br_tgt;
    assign bus.ir_op  = op_q;
    assign bus.ir_arg = arg_q;
    assign bus.ir_len = len_q;
    assign bus.flt    = CHK_EN && (state == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.mem_req  = 1'b0;
        bus.pc_oe    = 1'b0;
        bus.pc_ini   = 1'b0;
        bus.pc_lrc   = 1'b0;
        bus.ir_valid = 1'b0;
        lat_byte     = 1'b0;
        op_done      = 1'b0;
        clr_pend     = 1'b0;
        case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
                if (addr_bad) begin
                    state_nxt = FAULT;
                end else begin
                    bus.mem_req = 1'b1;
                    bus.pc_oe   = 1'b1;
                    if (bus.mem_ack) begin
                        if (pend_any) begin
                            state_nxt = REDIR;
                        end else begin
                            lat_byte  = 1'b1;
                            state_nxt = INC;
                        end
                    end
                end
            end
            INC: begin
                bus.pc_ini = 1'b1;
                state_nxt  = pend_any ? REDIR : SETTLE;
            end
            SETTLE: begin
                if (pend_any)                   state_nxt = REDIR;
                else if (need_op || idx != len_q) state_nxt = REQ;
                else                            state_nxt = ISSUE;
            end
            ISSUE: begin
                if (pend_any) begin
                    state_nxt = REDIR;
                end else begin
                    bus.ir_valid = 1'b1;
                    if (bus.ir_ready) begin
                        op_done   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REDIR: begin
                bus.pc_lrc = 1'b1;
                clr_pend   = 1'b1;
                state_nxt  = SETTLE;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            need_op <= 1'b1;
            idx     <= 2'd0;
            br_pend <= 1'b0;
            br_tgt  <= 16'h0000;
            op_q    <= 8'h00;
            arg_q   <= 24'h000000;
            len_q   <= 2'd0;
        end else begin
            // A newer br_take overwrites the target and keeps the request pending.
            if (bus.br_take && state != FAULT) begin
                br_pend <= 1'b1;
                br_tgt  <= bus.br_addr;
            end else if (clr_pend) begin
                br_pend <= 1'b0;
            end
            if (clr_pend || op_done) need_op <= 1'b1;
            if (lat_byte) begin
                if (need_op) begin
                    op_q    <= bus.mem_rdata;
                    arg_q   <= 24'h000000;
                    len_q   <= bus.mem_rdata[7:6];
                    idx     <= 2'd0;
                    need_op <= 1'b0;
                end else begin
                    case (idx)
                        2'd0:    arg_q[7:0]   <= bus.mem_rdata;
                        2'd1:    arg_q[15:8]  <= bus.mem_rdata;
                        default: arg_q[23:16] <= bus.mem_rdata;
                    endcase
                    idx <= idx + 2'd1;
                end
            end
        end
    end
endmodule
